riscv_apu_wb_buffer: RTL and testbench
======================================

Name: riscv_apu_wb_buffer

Overview:
Writeback buffer directly downstream of the APU dispatcher and the APU response channel. It captures each returned APU result (data, fflags, destination address from the dispatcher) and writes it to the shared register-file write port. When a higher-priority writer (LSU) owns the port that cycle, the result is queued and drained in order. It also reports read dependencies on queued, not-yet-written destinations so decode can stall.

Parameters:
DATA_WIDTH, 32, result data width
FLAGS_WIDTH, 5, fflags width
ADDR_WIDTH, 6, register address width (GPR 0-31, FPR 32-63)
DEPTH, 2, queue entries; legal 1..8
CNT_W, $clog2(DEPTH+1), width of count_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
apu_valid_i  in  1  APU result valid (response channel)
apu_result_i  in  DATA_WIDTH  result data
apu_flags_i  in  FLAGS_WIDTH  result fflags
apu_waddr_i  in  ADDR_WIDTH  destination from dispatcher waddr output
apu_ready_o  out  1  buffer can accept a result this cycle
wb_port_busy_i  in  1  higher-priority writer owns the write port this cycle
wb_we_o  out  1  register-file write enable
wb_waddr_o  out  ADDR_WIDTH  write address
wb_wdata_o  out  DATA_WIDTH  write data
fflags_we_o  out  1  fflags update strobe
fflags_o  out  FLAGS_WIDTH  fflags of the written result
read_regs_i  in  3*ADDR_WIDTH  decode source registers, packed [2:0][ADDR_WIDTH-1:0]
read_regs_valid_i  in  3  source valid bits
read_dep_o  out  1  a source matches a pending result
count_o  out  CNT_W  queued entries
pending_o  out  1  count_o != 0 or apu_valid_i
overflow_o  out  1  sticky: result presented while apu_ready_o low

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Storage: circular FIFO of DEPTH entries {addr, data, flags}. Read and write pointers wrap modulo DEPTH. Occupancy is held in a count register.
- Reset: count=0, pointers=0, overflow_o=0. All outputs are 0 except apu_ready_o=1. Reset mid-drain discards every queued entry without writing it.
- apu_ready_o = (count != DEPTH). It depends on state only, never on wb_port_busy_i.
- Port free when !wb_port_busy_i.
- Bypass: count==0, apu_valid_i, port free → write the input the same cycle (0-cycle latency). The entry is not stored.
- Drain: count>0, port free → write the head entry and pop it. The input is never written ahead of queued entries, so order is preserved.
- Enqueue: apu_valid_i & apu_ready_o & not bypassed → push. Minimum latency to write is 1 cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance. When full, a same-cycle pop does NOT allow a push, because ready is state-based.
- apu_valid_i & !apu_ready_o: the result is dropped and overflow_o sets. overflow_o clears only on reset.
- Port busy: wb_we_o=0, nothing pops, and pushes still occur if ready.
- Write outputs:
  - When wb_we_o=0: wb_waddr_o, wb_wdata_o and fflags_o are 0.
  - fflags_we_o equals wb_we_o.
- x0 writes (addr 0): passed through unchanged; the register file ignores them.
- read_dep_o: asserted when any valid read_regs_i[i] equals the address of any of:
  - a stored entry, including the head being written this cycle (conservative);
  - an input being enqueued this cycle.
  A bypassed input does not raise read_dep_o.
- count_o and pending_o are combinational from state and apu_valid_i.
- No state machine beyond FIFO state. Empty and full are derived from count.

Test Plan:
- Bypass: empty, apu_valid_i=1, addr=5, data=0xDEADBEEF, flags=0x01, busy=0 → same cycle wb_we_o=1, wb_waddr_o=5, wb_wdata_o=0xDEADBEEF, fflags_o=0x01; count_o stays 0.
- Queue and drain order: busy=1; results A (addr 3) then B (addr 40) on two cycles → count_o=2, apu_ready_o=0. Release busy → A is written the next cycle and B the cycle after; count returns to 0.
- Overflow: DEPTH=2, full, busy=1, third result presented → dropped, overflow_o=1 and stays 1 until rst_i. Queued entries are unaffected.
- Simultaneous push/pop: count=1 (addr 7), busy=0, new result addr 8 → addr 7 written, addr 8 stored, count_o stays 1. Next cycle addr 8 is written.
- Dependency: queued addr 12, read_regs_i[1]=12 with valid bit set → read_dep_o=1. Same register with valid bit 0 → read_dep_o=0. Bypassed addr 12 → read_dep_o=0.
- Reset mid-operation: count=2, assert rst_i for one cycle → count_o=0, wb_we_o=0 and apu_ready_o=1 on the following cycle. No stale write occurs after busy is released.

Source files
------------

// File: rtl/riscv_apu_wb_buffer.sv
// APU writeback buffer: bypasses or queues APU results onto the shared
// register-file write port and flags decode hazards on pending results.
module riscv_apu_wb_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int FLAGS_WIDTH = 5,
  parameter int ADDR_WIDTH  = 6,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       apu_valid_i,
  input  logic [DATA_WIDTH-1:0]      apu_result_i,
  input  logic [FLAGS_WIDTH-1:0]     apu_flags_i,
  input  logic [ADDR_WIDTH-1:0]      apu_waddr_i,
  output logic                       apu_ready_o,
  input  logic                       wb_port_busy_i,
  output logic                       wb_we_o,
  output logic [ADDR_WIDTH-1:0]      wb_waddr_o,
  output logic [DATA_WIDTH-1:0]      wb_wdata_o,
  output logic                       fflags_we_o,
  output logic [FLAGS_WIDTH-1:0]     fflags_o,
  input  logic [2:0][ADDR_WIDTH-1:0] read_regs_i,
  input  logic [2:0]                 read_regs_valid_i,
  output logic                       read_dep_o,
  output logic [CNT_W-1:0]           count_o,
  output logic                       pending_o,
  output logic                       overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0]  addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]  data_q [DEPTH];
  logic [FLAGS_WIDTH-1:0] flag_q [DEPTH];
  logic [DEPTH-1:0]       vld_q;
  logic [PTR_W-1:0]       rd_q, wr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;

  logic empty, port_free, bypass, pop, push;

  assign empty       = (cnt_q == '0);
  assign port_free   = !wb_port_busy_i;
  assign apu_ready_o = (cnt_q != CNT_FULL);
  assign bypass      = empty && apu_valid_i && port_free;
  assign pop         = !empty && port_free;
  assign push        = apu_valid_i && apu_ready_o && !bypass;
  assign count_o     = cnt_q;
  assign pending_o   = !empty || apu_valid_i;
  assign overflow_o  = ovf_q;

  // Control state: pointers, occupancy, per-slot valid, sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (apu_valid_i && !apu_ready_o)
        ovf_q <= 1'b1;
      if (push) begin
        vld_q[wr_q] <= 1'b1;
        wr_q <= (wr_q == PTR_MAX) ? '0 : wr_q + 1'b1;
      end
      if (pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q <= (rd_q == PTR_MAX) ? '0 : rd_q + 1'b1;
      end
      if (push && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (pop && !push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // Payload storage, written on push only
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_q] <= apu_waddr_i;
      data_q[wr_q] <= apu_result_i;
      flag_q[wr_q] <= apu_flags_i;
    end
  end

  // Write port mux: queued head has priority over the live input
  always_comb begin
    wb_we_o    = pop || bypass;
    wb_waddr_o = '0;
    wb_wdata_o = '0;
    fflags_o   = '0;
    if (pop) begin
      wb_waddr_o = addr_q[rd_q];
      wb_wdata_o = data_q[rd_q];
      fflags_o   = flag_q[rd_q];
    end else if (bypass) begin
      wb_waddr_o = apu_waddr_i;
      wb_wdata_o = apu_result_i;
      fflags_o   = apu_flags_i;
    end
  end

  assign fflags_we_o = wb_we_o;

  // Hazard check against stored slots and the entry being pushed
  always_comb begin
    read_dep_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (read_regs_valid_i[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (vld_q[j] && addr_q[j] == read_regs_i[i])
            read_dep_o = 1'b1;
        end
        if (push && apu_waddr_i == read_regs_i[i])
          read_dep_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_apu_wb_buffer.sv
// Directed bench for riscv_apu_wb_buffer (DEPTH=2): vector table
// plus a hand-written overflow persistence sequence.
module tb_riscv_apu_wb_buffer;

  logic            clk = 1'b0;
  logic            rst;
  logic            vld;
  logic [31:0]     dat;
  logic [4:0]      flg;
  logic [5:0]      adr;
  logic            rdy;
  logic            busy;
  logic            we;
  logic [5:0]      wa;
  logic [31:0]     wd;
  logic            fwe;
  logic [4:0]      ff;
  logic [2:0][5:0] rr;
  logic [2:0]      rv;
  logic            dep;
  logic [1:0]      cnt;
  logic            pend;
  logic            ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  riscv_apu_wb_buffer dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .apu_valid_i       (vld),
    .apu_result_i      (dat),
    .apu_flags_i       (flg),
    .apu_waddr_i       (adr),
    .apu_ready_o       (rdy),
    .wb_port_busy_i    (busy),
    .wb_we_o           (we),
    .wb_waddr_o        (wa),
    .wb_wdata_o        (wd),
    .fflags_we_o       (fwe),
    .fflags_o          (ff),
    .read_regs_i       (rr),
    .read_regs_valid_i (rv),
    .read_dep_o        (dep),
    .count_o           (cnt),
    .pending_o         (pend),
    .overflow_o        (ovf)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [5:0]  a;
    logic [31:0] d;
    logic [4:0]  f;
    logic        busy;
    logic [17:0] rr;
    logic [2:0]  rv;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [4:0]  wf;
    logic        rdy;
    logic        dep;
    logic [1:0]  cnt;
    logic        pend;
    logic        ovf;
  } vec_t;

  vec_t v [29];

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic va, logic [5:0] a, logic [31:0] d,
                       logic [4:0] f, logic b);
    rst = r; vld = va; adr = a; dat = d; flg = f; busy = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst vld a d f busy rr rv | we wa wd wf rdy dep cnt pend ovf
    v[0]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,0};
    v[1]  = '{0,1,5,32'hDEADBEEF,1,0,{6'd0,6'd5,6'd0},3'b010,
              1,5,32'hDEADBEEF,1,1,0,0,1,0};
    v[2]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,0};
    v[3]  = '{0,1,3,32'h11111111,2,1,{6'd0,6'd0,6'd3},3'b001,
              0,0,0,0,1,1,0,1,0};
    v[4]  = '{0,1,40,32'h22222222,4,1,{6'd3,6'd0,6'd0},3'b100,
              0,0,0,0,1,1,1,1,0};
    v[5]  = '{0,1,9,32'h33333333,1,1,{6'd0,6'd0,6'd9},3'b001,
              0,0,0,0,0,0,2,1,0};
    v[6]  = '{0,0,0,0,0,0,0,0, 1,3,32'h11111111,2,0,0,2,1,1};
    v[7]  = '{0,0,0,0,0,0,0,0, 1,40,32'h22222222,4,1,0,1,1,1};
    v[8]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,1};
    v[9]  = '{1,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,1};
    v[10] = '{0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,0};
    v[11] = '{0,1,7,32'h77770007,3,1,0,0, 0,0,0,0,1,0,0,1,0};
    v[12] = '{0,1,8,32'h88880008,5,0,{6'd0,6'd0,6'd8},3'b001,
              1,7,32'h77770007,3,1,1,1,1,0};
    v[13] = '{0,0,0,0,0,0,0,0, 1,8,32'h88880008,5,1,0,1,1,0};
    v[14] = '{0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,0};
    v[15] = '{0,1,12,32'hC0DE000C,0,1,{6'd0,6'd12,6'd0},3'b010,
              0,0,0,0,1,1,0,1,0};
    v[16] = '{0,0,0,0,0,1,{6'd0,6'd12,6'd0},3'b010,
              0,0,0,0,1,1,1,1,0};
    v[17] = '{0,0,0,0,0,1,{6'd0,6'd12,6'd0},3'b101,
              0,0,0,0,1,0,1,1,0};
    v[18] = '{0,0,0,0,0,0,{6'd0,6'd12,6'd0},3'b010,
              1,12,32'hC0DE000C,0,1,1,1,1,0};
    v[19] = '{0,1,12,32'h0000C0C0,6,0,{6'd0,6'd12,6'd0},3'b010,
              1,12,32'h0000C0C0,6,1,0,0,1,0};
    v[20] = '{0,1,20,32'h20202020,7,1,0,0, 0,0,0,0,1,0,0,1,0};
    v[21] = '{0,1,21,32'h21212121,8,1,0,0, 0,0,0,0,1,0,1,1,0};
    v[22] = '{0,1,22,32'h22220022,9,0,0,0,
              1,20,32'h20202020,7,0,0,2,1,0};
    v[23] = '{0,0,0,0,0,1,0,0, 0,0,0,0,1,0,1,1,1};
    v[24] = '{0,1,23,32'h23232323,9,1,0,0, 0,0,0,0,1,0,1,1,1};
    v[25] = '{1,0,0,0,0,1,0,0, 0,0,0,0,0,0,2,1,1};
    v[26] = '{0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,0};
    v[27] = '{0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,0};
    v[28] = '{0,1,0,32'h00000005,0,0,0,0, 1,0,32'h00000005,0,1,0,0,1,0};

    drive(1, 0, 0, 0, 0, 0);
    rr = '0;
    rv = '0;
    tick();
    tick();

    for (int i = 0; i < 29; i++) begin
      drive(v[i].rst, v[i].vld, v[i].a, v[i].d, v[i].f, v[i].busy);
      rr = v[i].rr;
      rv = v[i].rv;
      @(negedge clk);
      chk("we",      i, 32'(we),   32'(v[i].we));
      chk("fwe",     i, 32'(fwe),  32'(v[i].we));
      chk("waddr",   i, 32'(wa),   32'(v[i].wa));
      chk("wdata",   i, wd,        v[i].wd);
      chk("fflags",  i, 32'(ff),   32'(v[i].wf));
      chk("ready",   i, 32'(rdy),  32'(v[i].rdy));
      chk("dep",     i, 32'(dep),  32'(v[i].dep));
      chk("count",   i, 32'(cnt),  32'(v[i].cnt));
      chk("pending", i, 32'(pend), 32'(v[i].pend));
      chk("ovf",     i, 32'(ovf),  32'(v[i].ovf));
      tick();
    end

    // Overflow stays set across idle cycles and leaves queued data intact
    rr = '0;
    rv = '0;
    drive(0, 1, 30, 32'hA0A0A0A0, 1, 1);
    tick();
    drive(0, 1, 31, 32'hB1B1B1B1, 2, 1);
    tick();
    drive(0, 1, 33, 32'hC2C2C2C2, 3, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("seq_ovf", 100 + k, 32'(ovf), 32'd1);
      chk("seq_cnt", 100 + k, 32'(cnt), 32'd2);
      chk("seq_we",  100 + k, 32'(we),  32'd0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("seq_wa0", 110, 32'(wa), 32'd30);
    chk("seq_wd0", 110, wd, 32'hA0A0A0A0);
    tick();
    @(negedge clk);
    chk("seq_wa1", 111, 32'(wa), 32'd31);
    chk("seq_wd1", 111, wd, 32'hB1B1B1B1);
    tick();
    @(negedge clk);
    chk("seq_idle", 112, 32'(we), 32'd0);
    chk("seq_ovf2", 112, 32'(ovf), 32'd1);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("seq_clr", 113, 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
